tdc_mc_interval: RTL and testbench
==================================

# tdc_mc_interval

Parametrised multi-channel coarse time-interval digitiser; successor to the single-input `tdc` measurement core, running in the `clk_100m` domain behind the PLL and reset generator. It samples NCH asynchronous inputs and measures intervals in `clk_100m` cycles, either consecutive rising edges per channel or a shared start channel to per-channel stops. Results are tagged with a channel number and buffered in a FIFO for the UART formatter through a valid/ready stream.

## Interface
- NCH, 4: input channel count, 2..16; CH_W = clog2(NCH).
- CNT_W, 24: interval width in cycles.
- DEPTH, 16: result FIFO depth, power of 2, ≥2.
- SYNC_STAGES, 2: synchroniser flops per channel, ≥2.
- clk_100m  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- signal_in  in  NCH  asynchronous measured inputs.
- enable  in  1  measurement enable.
- mode  in  1  0 = period per channel, 1 = start-stop (channel 0 = start).
- m_valid  out  1  result available; reset 0.
- m_ready  in  1  consumer accepts result.
- m_interval  out  CNT_W  interval in cycles; reset 0.
- m_chan  out  CH_W  source channel; reset 0.
- m_sat  out  1  interval saturated; reset 0.
- fifo_full  out  1  FIFO holds DEPTH entries; reset 0.
- drop_cnt  out  16  lost events, saturating at 0xFFFF; reset 0.

## Operation
- Per channel: SYNC_STAGES-flop synchroniser, then prev-flop; edge pulse = sync & ~prev (one cycle per rising edge).
- Free-running timestamp `ts` (CNT_W) increments every cycle while enable=1, wraps modulo 2^CNT_W; held at 0 while enable=0.
- mode is latched on enable 0→1; ignored otherwise.
- enable=0: edge pulses ignored, all channels disarmed; pending registers and FIFO keep draining.
- Period mode: first edge on a disarmed channel stores `last`, arms, emits nothing; each later edge emits interval = edge-cycle difference, updates `last`.
- Start-stop mode: ch0 edge stores `start` for all stop channels, arms them, clears their `done` bits, emits nothing. Ch k>0 edge while armed and !done emits interval from the latest ch0 edge, sets done; else ignored. Simultaneous ch0 and chk edge: the chk edge refers to the previous start (or is ignored if unarmed), then the new start takes effect.
- Each channel has a one-entry pending register. New result with pending occupied: result dropped, drop_cnt+1 (saturating). Multiple simultaneous drops add count of drops.
- Round-robin arbiter: one pending entry per cycle moves into FIFO if !fifo_full; pointer advances to the channel after the granted one. FIFO full: pending entries wait.
- FIFO: first-word-fall-through; m_valid = !empty; pop on m_valid & m_ready. Push and pop in the same cycle allowed when not full; push gated by registered full flag only.
- Output fields are stable while m_valid & !m_ready.

## Timing
- Input edge → edge pulse: SYNC_STAGES+1 cycles (not guaranteed exact; ±1 cycle from metastability).
- Edge pulse cycle E → pending loaded at E+1 → FIFO write at E+2 → m_valid high from E+2 when FIFO was empty and no contention.
- Interval value: edge pulses at cycles E1, E2 ⇒ m_interval = E2−E1.
- Throughput: one FIFO push and one pop per cycle.
- rst_n low mid-operation: all state, FIFO, counters cleared immediately; outputs return to reset values asynchronously; in-flight results lost, not counted as drops.

## Configuration
- `TDC_SAT_EN` defined: each channel uses a saturating CNT_W age counter cleared on its reference edge; intervals ≥ 2^CNT_W−1 report all-ones with m_sat=1.
- Undefined: interval = ts − reference modulo 2^CNT_W (wraps silently); m_sat tied 0. Results identical in both builds for intervals < 2^CNT_W−1.

## Test plan
- Period mode, ch1 edges every 1000 cycles, m_ready=1 → first edge silent, then results {chan=1, interval=1000}, m_valid at E+2.
- Start-stop, ch0 edge then ch2 at +37, ch3 at +250, ch2 again at +300 → two results {2,37},{3,250}; third ignored.
- All 4 channels edge in the same cycle, m_ready=1 → four results on consecutive cycles in round-robin order, drop_cnt=0.
- m_ready=0, ch0 period edges every 4 cycles, DEPTH=16 → fifo_full after 16 results, pending fills, subsequent results increment drop_cnt; release m_ready → 17 results in order.
- CNT_W=8, period 300 cycles → with TDC_SAT_EN {255, m_sat=1}; without, {44, m_sat=0}.
- rst_n asserted with FIFO holding 5 entries → m_valid=0, drop_cnt=0, fifo_full=0 same cycle; first edge after release is silent.

Source files
------------

// File: rtl/tdc_mc_interval.sv
// tdc_mc_interval: multi-channel coarse time-interval digitiser.
//
// Each of NCH asynchronous inputs is synchronised and turned into a one-cycle
// rising-edge pulse. Intervals are measured in clk_100m cycles, either between
// consecutive edges of one channel (mode=0) or from the latest channel-0 edge
// to the first following edge of each other channel (mode=1). Results pass
// through a one-entry pending register per channel and a round-robin arbiter
// into a first-word-fall-through FIFO that feeds a valid/ready stream.
//
// Ports:
//   clk_100m    system clock
//   rst_n       asynchronous active-low reset
//   signal_in   NCH asynchronous measured inputs
//   enable      measurement enable; low disarms all channels and holds the timestamp
//   mode        0 = period per channel, 1 = start-stop; sampled on enable rising
//   m_valid     result available
//   m_ready     consumer accepts the current result
//   m_interval  interval in cycles
//   m_chan      source channel of the result
//   m_sat       interval saturated (always 0 unless TDC_SAT_EN)
//   fifo_full   result FIFO holds DEPTH entries
//   drop_cnt    results lost to an occupied pending register, saturating
//
// Build option: define TDC_SAT_EN to replace the shared wrapping timestamp with
// a saturating age counter per channel; intervals of 2^CNT_W-1 cycles or more
// then report all-ones with m_sat=1.

module tdc_mc_interval #(
  parameter int  NCH         = 4,
  parameter int  CNT_W       = 24,
  parameter int  DEPTH       = 16,
  parameter int  SYNC_STAGES = 2,
  localparam int CH_W        = $clog2(NCH)
) (
  input  logic             clk_100m,
  input  logic             rst_n,
  input  logic [NCH-1:0]   signal_in,
  input  logic             enable,
  input  logic             mode,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] m_interval,
  output logic [CH_W-1:0]  m_chan,
  output logic             m_sat,
  output logic             fifo_full,
  output logic [15:0]      drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  // synchronisers and edge detection
  logic [SYNC_STAGES-1:0] sync_q [NCH];
  logic [NCH-1:0]         prev_q;
  logic [NCH-1:0]         edge_p;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], signal_in[i]};
        prev_q[i] <= sync_q[i][SYNC_STAGES-1];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) edge_p[i] = sync_q[i][SYNC_STAGES-1] & ~prev_q[i];
  end

  // mode is captured on the enable rising edge and applies from that cycle on
  logic en_q, mode_q, mode_eff;
  assign mode_eff = (enable && !en_q) ? mode : mode_q;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      en_q <= enable;
      if (enable && !en_q) mode_q <= mode;
    end
  end

  // ref_load: this channel's reference is replaced this cycle.
  // res_v: this channel produces a result this cycle. A stop edge coinciding
  // with a start edge still measures against the old start because res_v reads
  // the registered reference before ref_load overwrites it.
  logic [NCH-1:0] armed_q, done_q, ref_load, res_v;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ref_load[i] = 1'b0;
      res_v[i]    = 1'b0;
      if (enable) begin
        if (mode_eff) begin
          if (i != 0) begin
            ref_load[i] = edge_p[0];
            res_v[i]    = edge_p[i] & armed_q[i] & ~done_q[i];
          end
        end else begin
          ref_load[i] = edge_p[i];
          res_v[i]    = edge_p[i] & armed_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= '0;
      done_q  <= '0;
    end else if (!enable) begin
      armed_q <= '0;
      done_q  <= '0;
    end else begin
      armed_q <= armed_q | ref_load;
      done_q  <= (done_q | res_v) & ~ref_load;
    end
  end

  logic [CNT_W-1:0] cur_int [NCH];
  logic [NCH-1:0]   cur_sat;

`ifdef TDC_SAT_EN
  // age = cycles since the reference edge; loading 1 makes age equal the
  // edge-to-edge difference on the cycle of the next edge
  logic [CNT_W-1:0] age_q [NCH];

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ref_load[i])      age_q[i] <= CNT_W'(1);
        else if (!(&age_q[i])) age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cur_int[i] = age_q[i];
      cur_sat[i] = &age_q[i];
    end
  end
`else
  logic [CNT_W-1:0] ts_q;
  logic [CNT_W-1:0] ref_q [NCH];

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      ts_q <= '0;
      for (int i = 0; i < NCH; i++) ref_q[i] <= '0;
    end else begin
      ts_q <= enable ? ts_q + 1'b1 : '0;
      for (int i = 0; i < NCH; i++) if (ref_load[i]) ref_q[i] <= ts_q;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cur_int[i] = ts_q - ref_q[i];
      cur_sat[i] = 1'b0;
    end
  end
`endif

  // pending registers and round-robin arbiter
  logic [NCH-1:0]   pend_v, pend_sat, grant_oh;
  logic [CNT_W-1:0] pend_int [NCH];
  logic [CH_W-1:0]  rr_q, grant_idx, lo_idx, hi_idx;
  logic             lo_any, hi_any, push, pop, full_q;
  logic [CNT_W-1:0] push_int;
  logic             push_sat;
  logic [4:0]       ndrop;
  logic [16:0]      drop_sum;

  // lowest pending index at/after the pointer wins, else lowest overall
  always_comb begin
    lo_any = 1'b0;
    hi_any = 1'b0;
    lo_idx = '0;
    hi_idx = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (pend_v[i]) begin
        lo_any = 1'b1;
        lo_idx = CH_W'(i);
        if (CH_W'(i) >= rr_q) begin
          hi_any = 1'b1;
          hi_idx = CH_W'(i);
        end
      end
    end
    grant_idx = hi_any ? hi_idx : lo_idx;
    push      = lo_any & ~full_q;
    push_int  = '0;
    push_sat  = 1'b0;
    ndrop     = '0;
    for (int i = 0; i < NCH; i++) begin
      grant_oh[i] = push && (grant_idx == CH_W'(i));
      if (grant_idx == CH_W'(i)) begin
        push_int = pend_int[i];
        push_sat = pend_sat[i];
      end
    end
    // a pending entry leaving this cycle frees its slot for a same-cycle result
    for (int i = 0; i < NCH; i++) ndrop = ndrop + 5'(res_v[i] & pend_v[i] & ~grant_oh[i]);
    drop_sum = {1'b0, drop_cnt} + {12'd0, ndrop};
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      pend_v   <= '0;
      pend_sat <= '0;
      for (int i = 0; i < NCH; i++) pend_int[i] <= '0;
      rr_q     <= '0;
      drop_cnt <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (res_v[i] && (!pend_v[i] || grant_oh[i])) begin
          pend_v[i]   <= 1'b1;
          pend_int[i] <= cur_int[i];
          pend_sat[i] <= cur_sat[i];
        end else if (grant_oh[i]) begin
          pend_v[i] <= 1'b0;
        end
      end
      if (push) rr_q <= (grant_idx == CH_W'(NCH-1)) ? '0 : grant_idx + 1'b1;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // result FIFO, first-word-fall-through
  logic [CNT_W-1:0] mem_int  [DEPTH];
  logic [CH_W-1:0]  mem_chan [DEPTH];
  logic [DEPTH-1:0] mem_sat;
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_nxt;

  assign m_valid = (cnt_q != '0);
  assign pop     = m_valid & m_ready;

  always_comb begin
    cnt_nxt = cnt_q;
    if (push && !pop)      cnt_nxt = cnt_q + 1'b1;
    else if (!push && pop) cnt_nxt = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_100m) begin
    if (push) begin
      mem_int[wr_q]  <= push_int;
      mem_chan[wr_q] <= grant_idx;
      mem_sat[wr_q]  <= push_sat;
    end
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q  <= cnt_nxt;
      full_q <= (cnt_nxt == (AW+1)'(DEPTH));
    end
  end

  // storage is not reset, so outputs are forced to zero while empty
  assign m_interval = m_valid ? mem_int[rd_q]  : '0;
  assign m_chan     = m_valid ? mem_chan[rd_q] : '0;
  assign m_sat      = m_valid & mem_sat[rd_q];
  assign fifo_full  = full_q;

endmodule

// File: tb/tb_tdc_mc_interval.sv
module tb_tdc_mc_interval;

  logic        clk_100m = 1'b0;
  logic        rst_n;
  logic [3:0]  signal_in;
  logic        enable, mode, m_ready;
  logic        m_valid, m_sat, fifo_full;
  logic [23:0] m_interval;
  logic [1:0]  m_chan;
  logic [15:0] drop_cnt;

  logic [1:0]  sig_s;
  logic        m_ready_s, m_valid_s, m_sat_s, fifo_full_s;
  logic [7:0]  m_interval_s;
  logic [0:0]  m_chan_s;
  logic [15:0] drop_cnt_s;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [1:0]  got_chan[$];
  logic [23:0] got_int[$];
  logic        got_sat[$];
  int          got_cyc[$];
  logic [7:0]  gs_int[$];
  logic        gs_sat[$];

  tdc_mc_interval #(.NCH(4), .CNT_W(24), .DEPTH(16), .SYNC_STAGES(2)) dut (
    .clk_100m(clk_100m), .rst_n(rst_n), .signal_in(signal_in), .enable(enable),
    .mode(mode), .m_valid(m_valid), .m_ready(m_ready), .m_interval(m_interval),
    .m_chan(m_chan), .m_sat(m_sat), .fifo_full(fifo_full), .drop_cnt(drop_cnt));

  tdc_mc_interval #(.NCH(2), .CNT_W(8), .DEPTH(4), .SYNC_STAGES(2)) dut_s (
    .clk_100m(clk_100m), .rst_n(rst_n), .signal_in(sig_s), .enable(enable),
    .mode(mode), .m_valid(m_valid_s), .m_ready(m_ready_s), .m_interval(m_interval_s),
    .m_chan(m_chan_s), .m_sat(m_sat_s), .fifo_full(fifo_full_s), .drop_cnt(drop_cnt_s));

  always #5 clk_100m = ~clk_100m;

  always @(posedge clk_100m) cyc <= cyc + 1;

  always @(negedge clk_100m) begin
    if (rst_n && m_valid && m_ready) begin
      got_chan.push_back(m_chan);
      got_int.push_back(m_interval);
      got_sat.push_back(m_sat);
      got_cyc.push_back(cyc);
    end
    if (rst_n && m_valid_s && m_ready_s) begin
      gs_int.push_back(m_interval_s);
      gs_sat.push_back(m_sat_s);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_100m);
    #1;
  endtask

  task automatic clear_got();
    got_chan.delete(); got_int.delete(); got_sat.delete(); got_cyc.delete();
    gs_int.delete(); gs_sat.delete();
  endtask

  task automatic start_mode(input logic m);
    enable = 1'b0; signal_in = '0; sig_s = '0;
    step(6);
    mode = m; enable = 1'b1;
    step(6);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; mode = 1'b0; m_ready = 1'b1; m_ready_s = 1'b1;
    signal_in = '0; sig_s = '0;
    step(3);
    rst_n = 1'b1;
    step(2);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
    checks++; if (m_interval !== 24'd0) begin failures++; $display("FAIL reset_m_interval got=%0d exp=0", m_interval); end
    checks++; if (m_chan !== 2'd0) begin failures++; $display("FAIL reset_m_chan got=%0d exp=0", m_chan); end
    checks++; if (m_sat !== 1'b0) begin failures++; $display("FAIL reset_m_sat got=%0b exp=0", m_sat); end
    checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL reset_fifo_full got=%0b exp=0", fifo_full); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
  endtask

  // arbiter pointer starts at 0 after reset, so grants run 0,1,2,3
  task automatic test_simultaneous();
    start_mode(1'b0); m_ready = 1'b1; clear_got();
    signal_in = 4'hF; step(10); signal_in = '0; step(40);
    signal_in = 4'hF; step(10); signal_in = '0; step(20);
    checks++; if (got_chan.size() != 4) begin failures++; $display("FAIL simul_count got=%0d exp=4", got_chan.size()); end
    for (int i = 0; i < got_chan.size() && i < 4; i++) begin
      checks++; if (got_chan[i] !== 2'(i)) begin failures++; $display("FAIL simul_chan[%0d] got=%0d exp=%0d", i, got_chan[i], i); end
      checks++; if (got_int[i] !== 24'd50) begin failures++; $display("FAIL simul_interval[%0d] got=%0d exp=50", i, got_int[i]); end
      checks++; if (got_cyc[i] != got_cyc[0] + i) begin failures++; $display("FAIL simul_consecutive[%0d] got=%0d exp=%0d", i, got_cyc[i], got_cyc[0] + i); end
    end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL simul_drop_cnt got=%0d exp=0", drop_cnt); end
  endtask

  task automatic test_period();
    int d1;
    int lat;
    start_mode(1'b0); m_ready = 1'b1; clear_got();
    signal_in[1] = 1'b1; step(10); signal_in[1] = 1'b0; step(10);
    checks++; if (got_chan.size() != 0) begin failures++; $display("FAIL period_first_silent got=%0d exp=0", got_chan.size()); end
    step(980);
    signal_in[1] = 1'b1; d1 = cyc; step(10); signal_in[1] = 1'b0; step(990);
    signal_in[1] = 1'b1; step(10); signal_in[1] = 1'b0; step(20);
    checks++; if (got_chan.size() != 2) begin failures++; $display("FAIL period_count got=%0d exp=2", got_chan.size()); end
    for (int i = 0; i < got_chan.size() && i < 2; i++) begin
      checks++; if (got_chan[i] !== 2'd1) begin failures++; $display("FAIL period_chan[%0d] got=%0d exp=1", i, got_chan[i]); end
      checks++; if (got_int[i] !== 24'd1000) begin failures++; $display("FAIL period_interval[%0d] got=%0d exp=1000", i, got_int[i]); end
      checks++; if (got_sat[i] !== 1'b0) begin failures++; $display("FAIL period_sat[%0d] got=%0b exp=0", i, got_sat[i]); end
    end
    // input change to m_valid: synchroniser + edge flop, then pending and FIFO write
    if (got_cyc.size() > 0) begin
      lat = got_cyc[0] - d1;
      checks++; if (lat < 4 || lat > 5) begin failures++; $display("FAIL period_latency got=%0d exp=4..5", lat); end
    end
  endtask

  task automatic test_start_stop();
    start_mode(1'b1); m_ready = 1'b1; clear_got();
    for (int t = 0; t < 330; t++) begin
      signal_in[0] = (t < 10);
      signal_in[2] = (t >= 37 && t < 47) || (t >= 300 && t < 310);
      signal_in[3] = (t >= 250 && t < 260);
      step(1);
    end
    signal_in = '0; step(20);
    checks++; if (got_chan.size() != 2) begin failures++; $display("FAIL ss_count got=%0d exp=2", got_chan.size()); end
    if (got_chan.size() >= 2) begin
      checks++; if (got_chan[0] !== 2'd2 || got_int[0] !== 24'd37) begin failures++; $display("FAIL ss_first got=%0d/%0d exp=2/37", got_chan[0], got_int[0]); end
      checks++; if (got_chan[1] !== 2'd3 || got_int[1] !== 24'd250) begin failures++; $display("FAIL ss_second got=%0d/%0d exp=3/250", got_chan[1], got_int[1]); end
    end
  endtask

  task automatic test_sat();
    int exp_i[3];
    bit exp_s[3];
`ifdef TDC_SAT_EN
    exp_i = '{255, 255, 254}; exp_s = '{1'b1, 1'b1, 1'b0};
`else
    exp_i = '{44, 255, 254};  exp_s = '{1'b0, 1'b0, 1'b0};
`endif
    start_mode(1'b0); m_ready_s = 1'b1; clear_got();
    for (int t = 0; t < 830; t++) begin
      sig_s[0] = (t < 10) || (t >= 300 && t < 310) || (t >= 555 && t < 565) || (t >= 809 && t < 819);
      step(1);
    end
    sig_s = '0; step(20);
    checks++; if (gs_int.size() != 3) begin failures++; $display("FAIL sat_count got=%0d exp=3", gs_int.size()); end
    for (int i = 0; i < gs_int.size() && i < 3; i++) begin
      checks++; if (gs_int[i] != 8'(exp_i[i])) begin failures++; $display("FAIL sat_interval[%0d] got=%0d exp=%0d", i, gs_int[i], exp_i[i]); end
      checks++; if (gs_sat[i] !== exp_s[i]) begin failures++; $display("FAIL sat_flag[%0d] got=%0b exp=%0b", i, gs_sat[i], exp_s[i]); end
    end
  endtask

  task automatic test_random();
    for (int phase = 0; phase < 4; phase++) begin
      logic m;
      bit lvl[4];
      int hold[4];
      int last_t[4];
      bit arm_m[4], done_m[4];
      int start_t;
      int c;
      logic [3:0] rise;
      int exp_chan[$], exp_int[$];
      m = (phase == 0) ? 1'b0 : (phase == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      start_mode(m); clear_got();
      start_t = 0;
      for (int ch = 0; ch < 4; ch++) begin
        lvl[ch] = 1'b0; hold[ch] = $urandom_range(1, 20);
        last_t[ch] = 0; arm_m[ch] = 1'b0; done_m[ch] = 1'b0;
      end
      for (int t = 0; t < 600; t++) begin
        rise = '0;
        for (int ch = 0; ch < 4; ch++) begin
          hold[ch]--;
          if (hold[ch] == 0) begin
            lvl[ch] = ~lvl[ch];
            hold[ch] = $urandom_range(6, 20);
            if (lvl[ch]) rise[ch] = 1'b1;
          end
        end
        c = cyc;
        if (m == 1'b0) begin
          for (int ch = 0; ch < 4; ch++) if (rise[ch]) begin
            if (arm_m[ch]) begin exp_chan.push_back(ch); exp_int.push_back(c - last_t[ch]); end
            last_t[ch] = c; arm_m[ch] = 1'b1;
          end
        end else begin
          for (int ch = 1; ch < 4; ch++) if (rise[ch] && arm_m[ch] && !done_m[ch]) begin
            exp_chan.push_back(ch); exp_int.push_back(c - start_t); done_m[ch] = 1'b1;
          end
          if (rise[0]) begin
            start_t = c;
            for (int ch = 1; ch < 4; ch++) begin arm_m[ch] = 1'b1; done_m[ch] = 1'b0; end
          end
        end
        for (int ch = 0; ch < 4; ch++) signal_in[ch] = lvl[ch];
        m_ready = ($urandom_range(0, 7) != 0);
        step(1);
      end
      signal_in = '0; m_ready = 1'b1; step(40);
      for (int ch = 0; ch < 4; ch++) begin
        int ge[$];
        int ee[$];
        foreach (got_chan[i]) if (got_chan[i] == 2'(ch)) ge.push_back(int'(got_int[i]));
        foreach (exp_chan[i]) if (exp_chan[i] == ch) ee.push_back(exp_int[i]);
        checks++; if (ge.size() != ee.size()) begin failures++; $display("FAIL rand_p%0d_ch%0d_count got=%0d exp=%0d", phase, ch, ge.size(), ee.size()); end
        for (int i = 0; i < ee.size() && i < ge.size(); i++) begin
          checks++; if (ge[i] != ee[i]) begin failures++; $display("FAIL rand_p%0d_ch%0d[%0d] got=%0d exp=%0d", phase, ch, i, ge[i], ee[i]); end
        end
      end
      checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL rand_p%0d_drop_cnt got=%0d exp=0", phase, drop_cnt); end
    end
  endtask

  // 23 edges: 1 arms, 16 fill the FIFO, 1 waits in pending, 5 are dropped
  task automatic test_backpressure();
    start_mode(1'b0); m_ready = 1'b0; clear_got();
    for (int e = 0; e < 23; e++) begin
      signal_in[0] = 1'b1; step(2); signal_in[0] = 1'b0; step(2);
    end
    step(10);
    checks++; if (fifo_full !== 1'b1) begin failures++; $display("FAIL bp_fifo_full got=%0b exp=1", fifo_full); end
    checks++; if (drop_cnt !== 16'd5) begin failures++; $display("FAIL bp_drop_cnt got=%0d exp=5", drop_cnt); end
    checks++; if (m_valid !== 1'b1 || m_chan !== 2'd0 || m_interval !== 24'd4) begin failures++; $display("FAIL bp_head got=%0b/%0d/%0d exp=1/0/4", m_valid, m_chan, m_interval); end
    step(7);
    checks++; if (m_valid !== 1'b1 || m_interval !== 24'd4) begin failures++; $display("FAIL bp_head_stable got=%0b/%0d exp=1/4", m_valid, m_interval); end
    m_ready = 1'b1; step(40);
    checks++; if (got_chan.size() != 17) begin failures++; $display("FAIL bp_drain_count got=%0d exp=17", got_chan.size()); end
    for (int i = 0; i < got_chan.size(); i++) begin
      checks++; if (got_chan[i] !== 2'd0 || got_int[i] !== 24'd4) begin failures++; $display("FAIL bp_drain[%0d] got=%0d/%0d exp=0/4", i, got_chan[i], got_int[i]); end
    end
    checks++; if (fifo_full !== 1'b0 || m_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0b/%0b exp=0/0", fifo_full, m_valid); end
    checks++; if (drop_cnt !== 16'd5) begin failures++; $display("FAIL bp_drop_hold got=%0d exp=5", drop_cnt); end
  endtask

  task automatic test_reset_mid();
    start_mode(1'b0); m_ready = 1'b0; clear_got();
    for (int e = 0; e < 6; e++) begin
      signal_in[0] = 1'b1; step(2); signal_in[0] = 1'b0; step(2);
    end
    step(10);
    checks++; if (m_valid !== 1'b1 || drop_cnt !== 16'd5) begin failures++; $display("FAIL rmid_pre got=%0b/%0d exp=1/5", m_valid, drop_cnt); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rmid_m_valid got=%0b exp=0", m_valid); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL rmid_drop_cnt got=%0d exp=0", drop_cnt); end
    checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL rmid_fifo_full got=%0b exp=0", fifo_full); end
    checks++; if (m_interval !== 24'd0) begin failures++; $display("FAIL rmid_m_interval got=%0d exp=0", m_interval); end
    step(3);
    rst_n = 1'b1; m_ready = 1'b1;
    step(6);
    clear_got();
    signal_in[0] = 1'b1; step(10); signal_in[0] = 1'b0; step(20);
    checks++; if (got_chan.size() != 0) begin failures++; $display("FAIL rmid_first_silent got=%0d exp=0", got_chan.size()); end
    signal_in[0] = 1'b1; step(10); signal_in[0] = 1'b0; step(20);
    checks++; if (got_chan.size() != 1) begin failures++; $display("FAIL rmid_after_count got=%0d exp=1", got_chan.size()); end
    if (got_chan.size() > 0) begin
      checks++; if (got_int[0] !== 24'd30) begin failures++; $display("FAIL rmid_after_interval got=%0d exp=30", got_int[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_period();
    test_start_stop();
    test_sat();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
